// File: rtl/uart_mmio_bridge.sv
// Memory-mapped bridge between the CPU data port and a UART byte interface.
// Define UART_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise RX uses a single holding register.
module uart_mmio_bridge #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        RdEn,
  input  logic        WrEn,
  input  logic [7:0]  WrData,
  output logic [31:0] RdData,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady
);

  localparam int TxAw = $clog2(TX_DEPTH);
  localparam logic [1:0] AddrCtrl = 2'd0;
  localparam logic [1:0] AddrRx   = 2'd1;
  localparam logic [1:0] AddrTx   = 2'd2;
  localparam logic [1:0] AddrErr  = 2'd3;

  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 ||
      RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_mmio_bridge: FIFO depths must be powers of 2 and at least 2");
  end

  logic [7:0]    txMem [TX_DEPTH];
  logic [TxAw:0] txWrPtr, txRdPtr;
  logic          txEmpty, txFull, txPop, txWrite, txPush, txDrop;
  logic [7:0]    txDropCnt, rxOvfCnt;
  logic          errClr, rxCapture, rxPop, rxOvf, rxAvail;
  logic [7:0]    rxHead;

  // Full when the wrap bits differ but the index bits match.
  assign txEmpty = (txWrPtr == txRdPtr);
  assign txFull  = (txWrPtr[TxAw] != txRdPtr[TxAw]) &&
                   (txWrPtr[TxAw-1:0] == txRdPtr[TxAw-1:0]);
  assign TxValid = !txEmpty;
  assign TxData  = txEmpty ? 8'h00 : txMem[txRdPtr[TxAw-1:0]];
  assign txPop   = TxValid && TxReady;
  assign txWrite = WrEn && (Addr == AddrTx);
  assign txPush  = txWrite && (!txFull || txPop);
  assign txDrop  = txWrite && txFull && !txPop;

  assign errClr    = WrEn && (Addr == AddrErr);
  assign rxCapture = RxValid && RxReady;
  assign rxPop     = RdEn && (Addr == AddrRx) && rxAvail;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + 1'b1;
      if (txPop)  txRdPtr <= txRdPtr + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (txPush) txMem[txWrPtr[TxAw-1:0]] <= WrData;
  end

`ifdef UART_RX_FIFO_EN
  localparam int RxAw = $clog2(RX_DEPTH);
  logic [7:0]    rxMem [RX_DEPTH];
  logic [RxAw:0] rxWrPtr, rxRdPtr;
  logic          rxFull, rxPush;

  assign rxAvail = (rxWrPtr != rxRdPtr);
  assign rxFull  = (rxWrPtr[RxAw] != rxRdPtr[RxAw]) &&
                   (rxWrPtr[RxAw-1:0] == rxRdPtr[RxAw-1:0]);
  assign rxPush  = rxCapture && (!rxFull || rxPop);
  assign rxOvf   = rxCapture && rxFull && !rxPop;
  assign rxHead  = rxMem[rxRdPtr[RxAw-1:0]];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
      if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (rxPush) rxMem[rxWrPtr[RxAw-1:0]] <= RxData;
  end
`else
  logic [7:0] rxHold;
  logic       rxHoldFull;

  assign rxAvail = rxHoldFull;
  assign rxHead  = rxHold;
  assign rxOvf   = rxCapture && rxHoldFull && !rxPop;

  // A byte arriving alongside a pop replaces the one being read out.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rxHold     <= 8'h00;
      rxHoldFull <= 1'b0;
    end else if (rxCapture && (!rxHoldFull || rxPop)) begin
      rxHold     <= RxData;
      rxHoldFull <= 1'b1;
    end else if (rxPop) begin
      rxHoldFull <= 1'b0;
    end
  end
`endif

  // Saturating error counters; a clear wins over a same-cycle increment.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      txDropCnt <= 8'h00;
      rxOvfCnt  <= 8'h00;
    end else if (errClr) begin
      txDropCnt <= 8'h00;
      rxOvfCnt  <= 8'h00;
    end else begin
      if (txDrop && txDropCnt != 8'hFF) txDropCnt <= txDropCnt + 8'd1;
      if (rxOvf && rxOvfCnt != 8'hFF)   rxOvfCnt  <= rxOvfCnt + 8'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) RxReady <= 1'b0;
    else        RxReady <= 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      RdData <= 32'h0;
    end else if (RdEn) begin
      case (Addr)
        AddrCtrl: RdData <= {30'b0, rxAvail, !txFull};
        AddrRx:   RdData <= rxAvail ? {24'b0, rxHead} : 32'h0;
        AddrTx:   RdData <= 32'h0;
        default:  RdData <= {16'b0, txDropCnt, rxOvfCnt};
      endcase
    end
  end

endmodule
